extest_seq_ctrl: RTL

Sequencer for the EXTEST wrapper boundary scan chain. It accepts one test vector per handshake (input-cell pattern, expected output, compare mask) and drives extest_mode/en/extest_scan_in through the load, capture and unload phases. It collects extest_scan_out, compares the result and reports pass/fail with the full unloaded chain word. It sits between the test host / testbench and the wrapper, replacing hand-toggled mode and enable pins.

---
 rtl/extest_seq_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/extest_seq_ctrl.sv
// extest_seq_ctrl: sequences one EXTEST boundary-scan vector through the
// wrapper chain (load, capture, unload), compares the unloaded word and
// reports pass/fail together with the full chain word.
//
// Optional feature macro: EXTEST_ERRCNT_EN (adds err_clr / err_count).
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-high reset
//   vec_valid       test vector offered
//   vec_ready       combinational accept: IDLE and no abort
//   vec_in          pattern for the input wrapper cells (upper chain bits)
//   vec_exp         expected captured output-cell value
//   vec_mask        1 = compare this output bit
//   abort           synchronous abort of the running sequence
//   extest_mode     wrapper EXTEST mode
//   en              wrapper enable: 1 = shift, 0 = capture
//   extest_scan_in  serial data into the chain
//   extest_scan_out serial data out of the chain (chain bit 0)
//   busy            sequence in progress
//   res_valid       one-cycle result strobe
//   res_pass        compare result, held until the next result
//   res_data        unloaded chain word, held until the next result
//   err_clr         (EXTEST_ERRCNT_EN) synchronous clear of err_count
//   err_count       (EXTEST_ERRCNT_EN) saturating count of failed results
module extest_seq_ctrl #(
   parameter int unsigned CHAIN_LEN      = 8,
   parameter int unsigned IN_CELLS       = 4,
   parameter int unsigned CAPTURE_CYCLES = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            vec_valid,
   output logic                            vec_ready,
   input  logic [IN_CELLS-1:0]             vec_in,
   input  logic [CHAIN_LEN-IN_CELLS-1:0]   vec_exp,
   input  logic [CHAIN_LEN-IN_CELLS-1:0]   vec_mask,
   input  logic                            abort,
   output logic                            extest_mode,
   output logic                            en,
   output logic                            extest_scan_in,
   input  logic                            extest_scan_out,
   output logic                            busy,
   output logic                            res_valid,
   output logic                            res_pass,
`ifdef EXTEST_ERRCNT_EN
   input  logic                            err_clr,
   output logic [15:0]                     err_count,
`endif
   output logic [CHAIN_LEN-1:0]            res_data
);

   localparam int unsigned OUT_CELLS = CHAIN_LEN - IN_CELLS;
   localparam int unsigned CNT_W     = $clog2(CHAIN_LEN);
   localparam int unsigned CAP_W     = 4;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAPTURE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHIFT_IN  = 3'd1,
      CAPTURE   = 3'd2,
      SHIFT_OUT = 3'd3,
      REPORT    = 3'd4
   } state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
   logic [CAP_W-1:0]       cap_cnt, cap_cnt_nxt;
   logic [CHAIN_LEN-1:0]   load_q, load_nxt;
   logic [OUT_CELLS-1:0]   exp_q, exp_nxt;
   logic [OUT_CELLS-1:0]   mask_q, mask_nxt;
   logic [CHAIN_LEN-1:0]   rx_q, rx_nxt;
   logic                   mode_nxt, en_nxt, scan_in_nxt, busy_nxt;
   logic                   res_valid_nxt, res_pass_nxt;
   logic [CHAIN_LEN-1:0]   res_data_nxt;

   assign vec_ready = (state == IDLE) && !abort;

   // State, counters, vector latches and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         cap_cnt        <= '0;
         load_q         <= '0;
         exp_q          <= '0;
         mask_q         <= '0;
         rx_q           <= '0;
         extest_mode    <= 1'b0;
         en             <= 1'b0;
         extest_scan_in <= 1'b0;
         busy           <= 1'b0;
         res_valid      <= 1'b0;
         res_pass       <= 1'b0;
         res_data       <= '0;
      end else begin
         state          <= state_nxt;
         bit_cnt        <= bit_cnt_nxt;
         cap_cnt        <= cap_cnt_nxt;
         load_q         <= load_nxt;
         exp_q          <= exp_nxt;
         mask_q         <= mask_nxt;
         rx_q           <= rx_nxt;
         extest_mode    <= mode_nxt;
         en             <= en_nxt;
         extest_scan_in <= scan_in_nxt;
         busy           <= busy_nxt;
         res_valid      <= res_valid_nxt;
         res_pass       <= res_pass_nxt;
         res_data       <= res_data_nxt;
      end
   end

   // Next state, then Moore outputs decoded from the next state
   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      cap_cnt_nxt   = cap_cnt;
      load_nxt      = load_q;
      exp_nxt       = exp_q;
      mask_nxt      = mask_q;
      rx_nxt        = rx_q;
      mode_nxt      = 1'b0;
      en_nxt        = 1'b0;
      scan_in_nxt   = 1'b0;
      busy_nxt      = 1'b0;
      res_valid_nxt = 1'b0;
      res_pass_nxt  = res_pass;
      res_data_nxt  = res_data;

      case (state)
         IDLE: begin
            if (vec_valid && vec_ready) begin
               state_nxt = SHIFT_IN;
               load_nxt  = {vec_in, {OUT_CELLS{1'b0}}};
               exp_nxt   = vec_exp;
               mask_nxt  = vec_mask;
            end
         end
         SHIFT_IN: begin
            if (bit_cnt == BIT_LAST) state_nxt = CAPTURE;
            else                     bit_cnt_nxt = bit_cnt + CNT_W'(1);
         end
         CAPTURE: begin
            if (cap_cnt == CAP_LAST) state_nxt = SHIFT_OUT;
            else                     cap_cnt_nxt = cap_cnt + CAP_W'(1);
         end
         SHIFT_OUT: begin
            // chain bit k is presented during shift cycle k
            rx_nxt[bit_cnt] = extest_scan_out;
            if (bit_cnt == BIT_LAST) state_nxt = REPORT;
            else                     bit_cnt_nxt = bit_cnt + CNT_W'(1);
         end
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // REPORT is excluded so an abort there cannot swallow the result
      if (abort && (state == SHIFT_IN || state == CAPTURE || state == SHIFT_OUT))
         state_nxt = IDLE;

      // Counters restart on every phase change
      if (state_nxt != state) begin
         bit_cnt_nxt = '0;
         cap_cnt_nxt = '0;
      end

      case (state_nxt)
         SHIFT_IN: begin
            mode_nxt    = 1'b1;
            en_nxt      = 1'b1;
            scan_in_nxt = load_nxt[bit_cnt_nxt];
            busy_nxt    = 1'b1;
         end
         CAPTURE: begin
            mode_nxt = 1'b1;
            busy_nxt = 1'b1;
         end
         SHIFT_OUT: begin
            mode_nxt = 1'b1;
            en_nxt   = 1'b1;
            busy_nxt = 1'b1;
         end
         REPORT: begin
            busy_nxt      = 1'b1;
            res_valid_nxt = 1'b1;
            res_data_nxt  = rx_nxt;
            // upper-bit term checks the input pattern came back intact
            res_pass_nxt  = (((rx_nxt[OUT_CELLS-1:0] ^ exp_q) & mask_q) == '0) &&
                            (rx_nxt[CHAIN_LEN-1:OUT_CELLS] == load_q[CHAIN_LEN-1:OUT_CELLS]);
         end
         default: begin
         end
      endcase
   end

`ifdef EXTEST_ERRCNT_EN
   // Saturating failed-result counter; clear wins over increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_count <= '0;
      else if (err_clr)
         err_count <= '0;
      else if (state_nxt == REPORT && !res_pass_nxt && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`endif

endmodule
